keypad4x4_scan: RTL
===================

# keypad4x4_scan

Scanning input peripheral for the board's 4x4 matrix keypad. It drives one keypad row low at a time, samples the column lines, and debounces over whole scan frames. Each accepted key press is reported as a 4-bit code with a valid/read handshake. Accepted codes are also shifted into a 32-bit digit register, so the CPU bus or the seven-segment display peripheral can show the last eight keys entered.

## Interface
Parameters:
- SCAN_DIV, 16384: clk cycles each row is driven before its columns are sampled; must be ≥ 4.
- DEBOUNCE, 4: consecutive identical frames required to accept a press or a release; must be ≥ 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_col  in  4  keypad column lines, active-low (pulled up), asynchronous to clk
- cs  in  1  read strobe; one-cycle pulse acknowledges the current key
- o_row  out  4  row drive, active-low, exactly one bit low at any time
- o_key  out  4  code of the last accepted key
- o_valid  out  1  unread key present in o_key
- o_overrun  out  1  sticky: a key was accepted while o_valid was already 1
- o_data  out  32  last eight accepted codes; newest code in [3:0]

## Operation
- i_col passes through a 2-FF synchronizer before any use.
- Prescaler counts 0..SCAN_DIV-1. The tick is the cycle in which the count equals SCAN_DIV-1.
- Row pointer r (0..3). o_row = ~(1<<r).
- On tick:
  - Record the synchronized ~i_col into frame map bits [4r+3:4r].
  - Then advance r, wrapping from 3 to 0.
  - The tick for r=3 completes a frame.
- Key code for row r, column c = {r[1:0], c[1:0]}.
- Frame classification: NONE (no bits set), SINGLE(k) (exactly one bit set), MULTI (two or more bits set).
- FSM, evaluated only at frame completion; cnt counts matching frames:
  - IDLE:
    - SINGLE(k): cand←k, cnt←1. If DEBOUNCE=1, accept; else go to DEB.
    - NONE or MULTI: stay.
  - DEB:
    - SINGLE(cand): cnt+1. When cnt reaches DEBOUNCE, accept and go to HELD.
    - SINGLE(other): cand←other, cnt←1.
    - NONE or MULTI: go to IDLE.
  - HELD:
    - NONE: cnt←1. If DEBOUNCE=1, go to IDLE; else go to REL.
    - anything else: stay. Holding a key, or adding keys, never repeats a report.
  - REL:
    - NONE: cnt+1. When cnt reaches DEBOUNCE, go to IDLE.
    - anything else: go to HELD.
- Accept, in one cycle:
  - o_key←cand
  - o_data←{o_data[27:0], cand}
  - o_valid←1
  - o_overrun←1 if o_valid was 1 and cs=0; otherwise o_overrun is unchanged.
- cs=1 with no accept in the same cycle: o_valid←0 and o_overrun←0 on the next edge.
- cs=1 with accept in the same cycle: o_valid=1 and o_overrun=0 after the edge. The new key wins and the old key counts as read.
- cs with o_valid=0 has no effect besides clearing o_overrun.

## Timing
- Reset (async, immediate):
  - o_row=4'b1110
  - o_key=0, o_valid=0, o_overrun=0, o_data=0
  - prescaler=0, r=0, frame map=0, state IDLE, cnt=0
- Reset mid-frame or mid-debounce discards partial results. Scanning restarts at row 0 on the first clk after rst falls.
- Frame period = 4·SCAN_DIV cycles.
- Sampled column value = i_col from 2 cycles before the tick. Each row is settled for SCAN_DIV-2 cycles before it is sampled.
- Press latency: a key that is stable before a frame starts is accepted at the completion tick of its DEBOUNCE-th full frame. o_valid and o_data update on the following edge.
- All outputs are registered. o_row changes on the edge after a tick.

## Test plan
SCAN_DIV=4, DEBOUNCE=2 (frame = 16 cycles).
- Reset: assert rst mid-scan -> o_row=4'b1110 and all other outputs 0 immediately. The first frame after release samples rows in order 0,1,2,3.
- Clean press: hold row 2/column 1 (i_col=4'b1101 while o_row=4'b1011) for 3 frames -> exactly one accept, after 2 frames: o_key=4'h9, o_valid=1, o_data=32'h00000009. Hold 10 more frames -> no further accept. Release for 2 frames -> IDLE.
- Bounce: toggle column 0 on row 0 every 5 cycles for 4 frames, then hold steady 2 frames -> single accept, o_key=4'h0. No accept while toggling.
- Multi-key: hold keys 4'h1 and 4'h6 together for 5 frames -> no accept. Release 4'h6 -> 4'h1 accepted 2 frames later.
- Handshake/overrun: press 3, 7, 5 without cs -> o_data=32'h00000375, o_key=5, o_valid=1, o_overrun=1. Pulse cs -> both flags 0 on the next edge. cs coincident with an accept of key C -> o_valid=1, o_overrun=0, o_key=C.
- Wrap: enter keys 1..9 -> o_data=32'h23456789. The oldest code is dropped.

Source files
------------

// File: rtl/keypad4x4_scan.sv
// 4x4 matrix keypad scanner: row-at-a-time drive, frame-level debounce,
// valid/read handshake with sticky overrun and an eight-digit key history.
module keypad4x4_scan #(
  parameter int unsigned SCAN_DIV = 16384,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  i_col,
  input  logic        cs,
  output logic [3:0]  o_row,
  output logic [3:0]  o_key,
  output logic        o_valid,
  output logic        o_overrun,
  output logic [31:0] o_data
);

  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DEB  = 2'd1,
    S_HELD = 2'd2,
    S_REL  = 2'd3
  } state_t;

  logic [3:0]       col_meta;
  logic [3:0]       col_sync;
  logic [PRE_W-1:0] pre;
  logic [1:0]       row_ptr;
  logic [1:0]       row_nxt;
  logic [15:0]      frame_map;
  logic [15:0]      frame_c;
  logic             tick;
  logic             frame_done;
  logic [4:0]       ones;
  logic [3:0]       key_c;
  logic             is_none;
  logic             is_single;

  state_t           state, state_n;
  logic [3:0]       cand, cand_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             accept;

  // Column synchronizer; idle (pulled-up) value is all ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= i_col;
      col_sync <= col_meta;
    end
  end

  assign tick       = (pre == PRE_MAX);
  assign row_nxt    = row_ptr + 2'd1;
  assign frame_done = tick && (row_ptr == 2'd3);

  // Prescaler, row pointer and row drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre     <= '0;
      row_ptr <= 2'd0;
      o_row   <= 4'b1110;
    end else if (tick) begin
      pre     <= '0;
      row_ptr <= row_nxt;
      o_row   <= ~(4'b0001 << row_nxt);
    end else begin
      pre     <= pre + PRE_W'(1);
    end
  end

  // Frame map including the row being sampled this cycle
  always_comb begin
    frame_c = frame_map;
    frame_c[{row_ptr, 2'b00} +: 4] = ~col_sync;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_map <= '0;
    end else if (tick) begin
      frame_map <= frame_c;
    end
  end

  // Bit index of a set bit equals its key code {row, col}
  always_comb begin
    ones  = 5'd0;
    key_c = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame_c[i]) begin
        ones  = ones + 5'd1;
        key_c = 4'(i);
      end
    end
  end

  assign is_none   = (ones == 5'd0);
  assign is_single = (ones == 5'd1);
  assign cnt_inc   = cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cand  <= 4'd0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cand  <= cand_n;
      cnt   <= cnt_n;
    end
  end

  // Debounce FSM, advanced only on frame completion
  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    accept  = 1'b0;
    if (frame_done) begin
      case (state)
        S_IDLE: begin
          if (is_single) begin
            cand_n = key_c;
            cnt_n  = CNT_W'(1);
            if (DEBOUNCE == 1) begin
              accept  = 1'b1;
              state_n = S_HELD;
            end else begin
              state_n = S_DEB;
            end
          end
        end
        S_DEB: begin
          if (is_single && (key_c == cand)) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              accept  = 1'b1;
              state_n = S_HELD;
            end
          end else if (is_single) begin
            cand_n = key_c;
            cnt_n  = CNT_W'(1);
          end else begin
            state_n = S_IDLE;
          end
        end
        S_HELD: begin
          if (is_none) begin
            cnt_n   = CNT_W'(1);
            state_n = (DEBOUNCE == 1) ? S_IDLE : S_REL;
          end
        end
        S_REL: begin
          if (is_none) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_DONE) state_n = S_IDLE;
          end else begin
            state_n = S_HELD;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Key report and handshake; a simultaneous read counts the old key as read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_key     <= 4'd0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
      o_data    <= 32'd0;
    end else if (accept) begin
      o_key     <= cand_n;
      o_data    <= {o_data[27:0], cand_n};
      o_valid   <= 1'b1;
      o_overrun <= cs ? 1'b0 : (o_overrun | o_valid);
    end else if (cs) begin
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end
  end

endmodule
